// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register slave.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  // SDA level that means ACK on the bus
  localparam logic I2C_ACK      = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser plus one edge register for a single asynchronous bus line.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_reg_slave.sv
// Oversampled I2C slave with an auto-incrementing byte register file and host read port.
// SDA is only ever changed a fixed SDA_HOLD cycles after a detected SCL fall.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h77,
  parameter int         DEPTH    = 16,
  parameter int         PTR_W    = $clog2(DEPTH),
  parameter int         SDA_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata
);

  localparam int HOLD_W = $clog2(SDA_HOLD + 1);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic w_byte_done, w_addr_match, w_oe_want;
  logic [7:0] w_shift_in;
  logic [PTR_W-1:0] w_ptr_inc;
  i2c_state_t w_state_next;

  i2c_state_t       r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rw;
  logic [PTR_W-1:0] r_ptr;
  logic             r_ptr_pending;
  logic             r_busy;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_sda_oe;
  logic             r_oe_pend;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [7:0]       r_regs [DEPTH];

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .i_pin (scl_in),
    .level (w_scl_level),
    .rise  (w_scl_rise),
    .fall  (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .i_pin (sda_in),
    .level (w_sda_level),
    .rise  (w_sda_rise),
    .fall  (w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl_level;
  assign w_stop       = w_sda_rise & w_scl_level;
  assign w_shift_in   = {r_shift[6:0], w_sda_level};
  assign w_byte_done  = (r_bit_cnt == 3'd7);
  assign w_addr_match = (w_shift_in[7:1] == DEV_ADDR) && (w_shift_in[7:1] != 7'd0);
  assign w_ptr_inc    = r_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // START/STOP override any data sample that lands in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_oe_want    = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_WR_ACK: w_oe_want = 1'b1;
      ST_RD_BYTE:             w_oe_want = ~r_shift[7];
      default:                w_oe_want = 1'b0;
    endcase
    if (w_stop) begin
      w_state_next = ST_IDLE;
    end else if (w_start) begin
      w_state_next = ST_ADDR;
    end else if (w_scl_rise) begin
      case (r_state)
        ST_ADDR:     if (w_byte_done) w_state_next = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: w_state_next = (r_rw == I2C_RW_READ) ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (w_byte_done) w_state_next = ST_WR_ACK;
        ST_WR_ACK:   w_state_next = ST_WR_BYTE;
        ST_RD_BYTE:  if (w_byte_done) w_state_next = ST_RD_ACK;
        ST_RD_ACK:   w_state_next = (w_sda_level == I2C_ACK) ? ST_RD_BYTE : ST_WAIT_STOP;
        default:     w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'd0;
      r_rw          <= I2C_RW_WRITE;
      r_ptr         <= '0;
      r_ptr_pending <= 1'b0;
      r_busy        <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 8'd0;
      r_sda_oe      <= 1'b0;
      r_oe_pend     <= 1'b0;
      r_hold_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start)     r_busy <= 1'b1;
      else if (w_stop) r_busy <= 1'b0;

      if (w_start || w_stop) begin
        r_bit_cnt <= 3'd0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR: begin
            r_shift   <= w_shift_in;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) r_rw <= w_shift_in[0];
          end
          ST_ADDR_ACK: begin
            r_bit_cnt <= 3'd0;
            if (r_rw == I2C_RW_READ) r_shift <= r_regs[r_ptr];
            else                     r_ptr_pending <= 1'b1;
          end
          ST_WR_BYTE: begin
            r_shift   <= w_shift_in;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              if (r_ptr_pending) begin
                r_ptr         <= w_shift_in[PTR_W-1:0];
                r_ptr_pending <= 1'b0;
              end else begin
                r_regs[r_ptr] <= w_shift_in;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_shift_in;
                r_ptr         <= w_ptr_inc;
              end
            end
          end
          ST_WR_ACK: r_bit_cnt <= 3'd0;
          ST_RD_BYTE: begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_RD_ACK: begin
            r_ptr     <= w_ptr_inc;
            r_shift   <= r_regs[w_ptr_inc];
            r_bit_cnt <= 3'd0;
          end
          default: r_bit_cnt <= r_bit_cnt;
        endcase
      end

      // The SDA decision is captured at the SCL fall and applied after the hold delay.
      if (w_scl_fall) begin
        r_oe_pend  <= w_oe_want;
        r_hold_cnt <= HOLD_W'(SDA_HOLD);
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        if (r_hold_cnt == HOLD_W'(1)) r_sda_oe <= r_oe_pend;
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_regs[host_addr];

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged master, write/read scoreboards, SDA hold checker.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam int DEPTH    = 16;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int SDA_HOLD = 2;
  localparam int HALF     = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy, wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] host_addr = '0;
  logic [7:0] wr_data, host_rdata;
  wire sda_line = sda_m & ~sda_oe;

  int n_assert = 0;
  int n_fail = 0;
  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  model[DEPTH];
  int model_ptr = 0;

  i2c_reg_slave #(.DEV_ADDR(7'h77), .DEPTH(DEPTH), .SDA_HOLD(SDA_HOLD)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    repeat (3) @(negedge clk);
    sda_m = b;
    repeat (HALF - 3) @(negedge clk);
    scl_m = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    s = sda_line;
    repeat (HALF / 2) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      repeat (3) @(negedge clk);
      sda_m = 1'b1;
      repeat (HALF - 3) @(negedge clk);
      scl_m = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    sda_m = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    scl_m = 1'b0;
    $display("txn START busy=%0b", busy);
  endtask

  task automatic i2c_stop();
    repeat (3) @(negedge clk);
    sda_m = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    scl_m = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    sda_m = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    $display("txn STOP busy=%0b", busy);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    acked = (s == I2C_ACK);
    $display("txn WRITE 0x%02h ack=%0b", d, acked);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(master_ack ? 1'b0 : 1'b1, s);
    $display("txn READ 0x%02h master_ack=%0b", d, master_ack);
  endtask

  task automatic send_addr(input string tag, input logic [7:0] a, input logic exp_ack);
    logic ack;
    write_byte(a, ack);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic send_ptr(input logic [7:0] p);
    logic ack;
    write_byte(p, ack);
    check("ptr_ack", 32'(ack), 32'd1);
    model_ptr = p % DEPTH;
  endtask

  task automatic send_data(input logic [7:0] d);
    logic ack;
    exp_wr_q.push_back({4'(model_ptr), d});
    model[model_ptr] = d;
    model_ptr = (model_ptr + 1) % DEPTH;
    write_byte(d, ack);
    check("data_ack", 32'(ack), 32'd1);
  endtask

  task automatic recv_data(input logic master_ack);
    logic [7:0] d;
    exp_rd_q.push_back(model[model_ptr]);
    model_ptr = (model_ptr + 1) % DEPTH;
    read_byte(master_ack, d);
    check("rd_data", 32'(d), 32'(exp_rd_q.pop_front()));
  endtask

  task automatic host_chk(input string tag, input int idx);
    host_addr = PTR_W'(idx);
    #1;
    check(tag, 32'(host_rdata), 32'(model[idx]));
  endtask

  // Write scoreboard: every strobe must match the oldest pending expected write.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      $display("txn STROBE addr=%0d data=0x%02h", wr_addr, wr_data);
      check("strobe_width", 32'(prev_strobe), 32'd0);
      check("strobe_pending", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) check("strobe_addr_data", 32'({wr_addr, wr_data}), 32'(exp_wr_q.pop_front()));
    end
    prev_strobe <= wr_strobe;
  end

  // SDA hold checker: sda_oe may only move while SCL is low, 3+SDA_HOLD cycles after the pin fall.
  int fall_age = 1000;
  logic scl_prev = 1'b1, oe_prev = 1'b0, rst_recent = 1'b1;
  always @(posedge clk) begin
    #1;
    if (scl_prev && !scl_m) fall_age = 1;
    else if (fall_age < 1000) fall_age++;
    if (!rst && !rst_recent && sda_oe !== oe_prev) begin
      check("oe_change_age", 32'(fall_age), 32'(3 + SDA_HOLD));
      check("oe_change_scl_low", 32'(scl_m), 32'd0);
    end
    scl_prev = scl_m;
    oe_prev = sda_oe;
    rst_recent = rst;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    host_chk("rst_host3", 3);

    // Multi-byte write
    i2c_start();
    check("t1_busy_high", 32'(busy), 32'd1);
    send_addr("t1_addr_ack", 8'hEE, 1'b1);
    send_ptr(8'h03);
    send_data(8'hAB);
    send_data(8'hCD);
    i2c_stop();
    check("t1_busy_low", 32'(busy), 32'd0);
    host_chk("t1_host3", 3);
    host_chk("t1_host4", 4);

    // Pointer write, repeated START, two-byte read
    i2c_start();
    send_addr("t2_addr_w_ack", 8'hEE, 1'b1);
    send_ptr(8'h03);
    i2c_start();
    send_addr("t2_addr_r_ack", 8'hEF, 1'b1);
    recv_data(1'b1);
    recv_data(1'b0);
    i2c_stop();
    check("t2_ptr_after", 32'(dut.r_ptr), 32'(model_ptr));

    // Pointer wrap at DEPTH-1
    i2c_start();
    send_addr("t3_addr_ack", 8'hEE, 1'b1);
    send_ptr(8'h0F);
    send_data(8'h11);
    send_data(8'h22);
    i2c_stop();
    host_chk("t3_host15", 15);
    host_chk("t3_host0", 0);

    // Address mismatch: no ACK, no strobe, busy held until STOP
    i2c_start();
    send_addr("t4_mismatch_nack", 8'hA0, 1'b0);
    send_addr("t4_after_nack", 8'h55, 1'b0);
    check("t4_busy_held", 32'(busy), 32'd1);
    i2c_stop();
    check("t4_busy_low", 32'(busy), 32'd0);

    // Abort after 4 data bits, then reset in the middle of a read byte
    i2c_start();
    send_addr("t5_addr_ack", 8'hEE, 1'b1);
    send_ptr(8'h02);
    for (int i = 0; i < 4; i++) clk_bit(i[0], s);
    i2c_stop();
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_idle", 32'(dut.r_state), 32'(ST_IDLE));
    host_chk("t5_host2", 2);
    i2c_start();
    send_addr("t5_addr_r_ack", 8'hEF, 1'b1);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    repeat (8) @(negedge clk);
    check("t5_oe_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_oe_released", 32'(sda_oe), 32'd0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    model_ptr = 0;
    for (int i = 0; i < DEPTH; i++) host_chk("t5_reg_cleared", i);
    check("t5_ptr_cleared", 32'(dut.r_ptr), 32'(model_ptr));
    check("t5_busy_cleared", 32'(busy), 32'd0);

    repeat (4) @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
